// File: rtl/sram_access_ctrl_pkg.sv
// rtl/sram_access_ctrl_pkg.sv - size encodings, FSM states and lane-mask helper for sram_access_ctrl
package sram_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ACCESS2,
    ST_DONE
  } state_e;

  // [3:0] are the lanes of the addressed word, [7:4] the lanes spilling into the next word.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0F;
      default:   base = 8'h00;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - on-chip bus side of sram_access_ctrl (one request at a time)
interface sram_access_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [31:0]       wdata;
  logic              ready;
  logic              error;
  logic [31:0]       rdata;

  modport master (output req, wen, addr, size, wdata, input ready, error, rdata);
  modport slave  (input req, wen, addr, size, wdata, output ready, error, rdata);
endinterface

// File: rtl/sram_access_ctrl_lane_align.sv
// rtl/sram_access_ctrl_lane_align.sv - lane masks, write-data shift and read assembly
// Second-beat ports exist only with SRAM_CTRL_SPLIT_MISALIGNED_EN.
module sram_lane_align
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata0_i,
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
  input  logic [31:0] rdata1_i,
  output logic [3:0]  mask1_o,
  output logic [31:0] wdata1_o,
`endif
  output logic [3:0]  mask0_o,
  output logic [31:0] wdata0_o,
  output logic        split_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  mask;
  logic [4:0]  sh;
  logic [31:0] rd_raw;

  always_comb begin
    mask     = lane_mask(size_i, off_i);
    sh       = {off_i, 3'b000};
    mask0_o  = mask[3:0];
    split_o  = |mask[7:4];
    wdata0_o = wdata_i << sh;
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
    mask1_o  = mask[7:4];
    wdata1_o = wdata_i >> (6'd32 - {1'b0, sh});
    rd_raw   = 32'({rdata1_i, rdata0_i} >> sh);
`else
    rd_raw   = rdata0_i >> sh;
`endif
    case (size_i)
      SIZE_BYTE: rdata_o = {24'b0, rd_raw[7:0]};
      SIZE_HALF: rdata_o = {16'b0, rd_raw[15:0]};
      default:   rdata_o = rd_raw;
    endcase
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - sequential SRAM bank access controller, all outputs registered
// SRAM_CTRL_SPLIT_MISALIGNED_EN builds ACCESS2 so misaligned accesses become two beats.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                N_SRAM         = 2,
  parameter int                SRAM_DEPTH     = 1024,
  parameter int                ADDR_W         = 32,
  parameter int                WAIT_STATES    = 1,
  parameter logic [3:0]        INVERT_BYTE_EN = 4'hF,
  parameter logic [N_SRAM-1:0] INVERT_CE_EN   = '1
) (
  input  logic                          CLK,
  input  logic                          RST,
  sram_access_ctrl_if.slave             bus,
  output logic [N_SRAM-1:0]             sram_ce,
  output logic                          sram_we,
  output logic [$clog2(SRAM_DEPTH)-1:0] sram_addr,
  output logic [3:0]                    sram_byte_en,
  output logic [31:0]                   sram_wdata,
  input  logic [31:0]                   sram_rdata
);

  localparam int                AW      = $clog2(SRAM_DEPTH);
  localparam int                BW      = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
  localparam int                HW      = ADDR_W - AW - 2;
  localparam logic [HW:0]       N_BANKS = (HW+1)'(N_SRAM);
  localparam logic [3:0]        WS      = 4'(WAIT_STATES);
  localparam logic [N_SRAM-1:0] CE_ONE  = N_SRAM'(1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        off_q, off_d, size_q, size_d;
  logic              wen_q, wen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d, error_q, error_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [N_SRAM-1:0] ce_q, ce_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       swdata_q, swdata_d;

  logic [HW:0]       in_bank;
  logic [AW-1:0]     in_word;
  logic              in_legal;
  logic [1:0]        la_size, la_off;
  logic [31:0]       la_wdata, la_wdata0, la_rdata;
  logic [3:0]        la_mask0;
  logic              la_split;
  logic              done_now;

`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
  logic [BW-1:0]     bank_q, bank_d, nxt_bank;
  logic [AW-1:0]     word_q, word_d;
  logic              split_q, split_d;
  logic [31:0]       beat0_q, beat0_d;
  logic [31:0]       la_rdata0, la_wdata1;
  logic [3:0]        la_mask1;
  logic [HW:0]       in_bank2;
`endif

  assign in_bank  = {1'b0, bus.addr[ADDR_W-1:AW+2]};
  assign in_word  = bus.addr[AW+1:2];
  assign la_size  = (state_q == ST_IDLE) ? bus.size      : size_q;
  assign la_off   = (state_q == ST_IDLE) ? bus.addr[1:0] : off_q;
  assign la_wdata = (state_q == ST_IDLE) ? bus.wdata     : wdata_q;

`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
  // The second beat of the last word in a bank lands on word 0 of the next bank.
  assign in_bank2  = in_bank + (HW+1)'(in_word == '1);
  assign nxt_bank  = (word_q == '1) ? bank_q + BW'(1) : bank_q;
  assign la_rdata0 = (state_q == ST_ACCESS) ? sram_rdata : beat0_q;
  assign in_legal  = (bus.size != 2'd3) && (in_bank < N_BANKS) && (!la_split || (in_bank2 < N_BANKS));
`else
  assign in_legal  = (bus.size != 2'd3) && (in_bank < N_BANKS) && !la_split;
`endif

  sram_lane_align u_lane_align (
    .size_i   (la_size),
    .off_i    (la_off),
    .wdata_i  (la_wdata),
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
    .rdata0_i (la_rdata0),
    .rdata1_i (sram_rdata),
    .mask1_o  (la_mask1),
    .wdata1_o (la_wdata1),
`else
    .rdata0_i (sram_rdata),
`endif
    .mask0_o  (la_mask0),
    .wdata0_o (la_wdata0),
    .split_o  (la_split),
    .rdata_o  (la_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    size_d   = size_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    ready_d  = 1'b0;
    error_d  = 1'b0;
    rdata_d  = rdata_q;
    ce_d     = INVERT_CE_EN;
    we_d     = 1'b0;
    addr_d   = addr_q;
    be_d     = INVERT_BYTE_EN;
    swdata_d = swdata_q;
    done_now = 1'b0;
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
    bank_d   = bank_q;
    word_d   = word_q;
    split_d  = split_q;
    beat0_d  = beat0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          off_d   = bus.addr[1:0];
          size_d  = bus.size;
          wen_d   = bus.wen;
          wdata_d = bus.wdata;
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
          bank_d  = in_bank[BW-1:0];
          word_d  = in_word;
          split_d = la_split;
`endif
          if (in_legal) begin
            state_d  = ST_ACCESS;
            cnt_d    = WS;
            ce_d     = (CE_ONE << in_bank[BW-1:0]) ^ INVERT_CE_EN;
            we_d     = bus.wen;
            addr_d   = in_word;
            be_d     = la_mask0 ^ INVERT_BYTE_EN;
            swdata_d = la_wdata0;
          end else begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            error_d = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          ce_d  = ce_q;
          we_d  = we_q;
          be_d  = be_q;
        end else begin
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
          beat0_d = sram_rdata;
          if (split_q) begin
            state_d  = ST_ACCESS2;
            cnt_d    = WS;
            ce_d     = (CE_ONE << nxt_bank) ^ INVERT_CE_EN;
            we_d     = wen_q;
            addr_d   = word_q + AW'(1);
            be_d     = la_mask1 ^ INVERT_BYTE_EN;
            swdata_d = la_wdata1;
          end else begin
            done_now = 1'b1;
          end
`else
          done_now = 1'b1;
`endif
        end
      end
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
      ST_ACCESS2: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          ce_d  = ce_q;
          we_d  = we_q;
          be_d  = be_q;
        end else begin
          done_now = 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (done_now) begin
      state_d = ST_DONE;
      ready_d = 1'b1;
      rdata_d = wen_q ? 32'h0 : la_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      off_q    <= '0;
      size_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      rdata_q  <= '0;
      ce_q     <= INVERT_CE_EN;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= INVERT_BYTE_EN;
      swdata_q <= '0;
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
      bank_q   <= '0;
      word_q   <= '0;
      split_q  <= 1'b0;
      beat0_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      size_q   <= size_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      rdata_q  <= rdata_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      swdata_q <= swdata_d;
`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
      bank_q   <= bank_d;
      word_q   <= word_d;
      split_q  <= split_d;
      beat0_q  <= beat0_d;
`endif
    end
  end

  assign bus.ready    = ready_q;
  assign bus.error    = error_q;
  assign bus.rdata    = rdata_q;
  assign sram_ce      = ce_q;
  assign sram_we      = we_q;
  assign sram_addr    = addr_q;
  assign sram_byte_en = be_q;
  assign sram_wdata   = swdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed scoreboard bench for sram_access_ctrl
// Expectations follow SRAM_CTRL_SPLIT_MISALIGNED_EN for the misaligned steps.
module tb_sram_access_ctrl;
  import sram_ctrl_pkg::*;

  localparam int         W      = 1;
  localparam logic [3:0] BE_INV = 4'h0;
  localparam logic [1:0] CE_INV = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_access_ctrl_if #(.ADDR_W(32)) bus ();
  logic [1:0]  sram_ce;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [3:0]  sram_byte_en;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_access_ctrl #(
    .N_SRAM(2), .SRAM_DEPTH(1024), .ADDR_W(32), .WAIT_STATES(W),
    .INVERT_BYTE_EN(BE_INV), .INVERT_CE_EN(CE_INV)
  ) dut (
    .CLK(clk), .RST(rst), .bus(bus),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_byte_en(sram_byte_en), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  typedef struct { logic [31:0] rdata; logic err; int lat; logic is_rd; } exp_t;
  typedef struct { logic [1:0] ce; logic [9:0] addr; logic [3:0] be; logic we; logic [31:0] wd; } beat_t;
  exp_t  exp_q[$];
  beat_t beats[$];
  int    n_cmp = 0;
  int    n_mis = 0;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [1:0]  ce_act;
  logic [3:0]  be_act;
  assign ce_act = sram_ce ^ CE_INV;
  assign be_act = sram_byte_en ^ BE_INV;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    sram_rdata = 32'h0;
    if (ce_act == 2'b01) sram_rdata = mem0[sram_addr];
    else if (ce_act == 2'b10) sram_rdata = mem1[sram_addr];
  end

  always @(posedge clk) begin
    if (rst) begin
      mem0[0]      <= 32'hAABBCCDD;
      mem0[1]      <= 32'h0;
      mem0[10'h3FF] <= 32'hAABBCCDD;
      mem1[0]      <= 32'h11223344;
    end else if (sram_we) begin
      if (ce_act == 2'b01) mem0[sram_addr] <= merge(mem0[sram_addr], sram_wdata, be_act);
      else if (ce_act == 2'b10) mem1[sram_addr] <= merge(mem1[sram_addr], sram_wdata, be_act);
    end
  end

  always @(negedge clk) begin
    if (ce_act != 2'b00) beats.push_back('{sram_ce, sram_addr, sram_byte_en, sram_we, sram_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
    int   n;
    logic seen;
    exp_t e;
    beats.delete();
    exp_q.push_back('{rdata: er, err: ee, lat: el, is_rd: !w});
    @(negedge clk);
    bus.req = 1'b1; bus.wen = w; bus.addr = a; bus.size = s; bus.wdata = wd;
    @(posedge clk);
    #1 bus.req = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.ready) seen = 1'b1;
    end
    chk({tag, "_ready_seen"}, 64'(seen), 64'd1);
    e = exp_q.pop_front();
    chk({tag, "_latency"}, 64'(n), 64'(e.lat));
    chk({tag, "_error"}, 64'(bus.error), 64'(e.err));
    if (e.is_rd && !e.err) chk({tag, "_rdata"}, 64'(bus.rdata), 64'(e.rdata));
    @(negedge clk);
    chk({tag, "_ready_pulse"}, 64'(bus.ready), 64'd0);
  endtask

  task automatic chk_beats(input string tag, input int nb, input logic we,
                           input logic [1:0] ce0, input logic [9:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                           input logic [1:0] ce1, input logic [9:0] a1, input logic [3:0] be1, input logic [31:0] wd1);
    logic [48:0] o, x;
    chk({tag, "_beat_cycles"}, 64'(beats.size()), 64'(nb * (W + 1)));
    for (int k = 0; k < beats.size() && k < nb * (W + 1); k++) begin
      o = {beats[k].ce, beats[k].addr, beats[k].be, beats[k].we, beats[k].wd};
      if (k < W + 1) x = {ce0 ^ CE_INV, a0, be0 ^ BE_INV, we, wd0};
      else           x = {ce1 ^ CE_INV, a1, be1 ^ BE_INV, we, wd1};
      chk($sformatf("%s_cyc%0d", tag, k), 64'(o), 64'(x));
    end
  endtask

  initial begin
    logic got;
    bus.req = 1'b0; bus.wen = 1'b0; bus.addr = 32'h0; bus.size = SIZE_BYTE; bus.wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_ce", 64'(sram_ce), 64'(CE_INV));
    chk("rst_be", 64'(sram_byte_en), 64'(BE_INV));
    chk("rst_we", 64'(sram_we), 64'd0);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_wdata", 64'(sram_wdata), 64'd0);
    rst = 1'b0;

    do_req("wr_word", 1'b1, 32'h1004, SIZE_WORD, 32'h11223344, 32'h0, 1'b0, 3);
    chk_beats("wr_word", 1, 1'b1, 2'b10, 10'd1, 4'hF, 32'h11223344, 2'b00, 10'd0, 4'h0, 32'h0);
    do_req("rd_byte", 1'b0, 32'h0002, SIZE_BYTE, 32'h0, 32'h000000BB, 1'b0, 3);
    chk_beats("rd_byte", 1, 1'b0, 2'b01, 10'd0, 4'b0100, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);
    do_req("rd_word", 1'b0, 32'h1004, SIZE_WORD, 32'h0, 32'h11223344, 1'b0, 3);
    chk_beats("rd_word", 1, 1'b0, 2'b10, 10'd1, 4'hF, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);
    do_req("rd_half", 1'b0, 32'h0002, SIZE_HALF, 32'h0, 32'h0000AABB, 1'b0, 3);
    chk_beats("rd_half", 1, 1'b0, 2'b01, 10'd0, 4'b1100, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);
    do_req("wr_byte", 1'b1, 32'h0005, SIZE_BYTE, 32'h0000005A, 32'h0, 1'b0, 3);
    chk_beats("wr_byte", 1, 1'b1, 2'b01, 10'd1, 4'b0010, 32'h00005A00, 2'b00, 10'd0, 4'h0, 32'h0);
    do_req("rd_byte5", 1'b0, 32'h0005, SIZE_BYTE, 32'h0, 32'h0000005A, 1'b0, 3);
    chk_beats("rd_byte5", 1, 1'b0, 2'b01, 10'd1, 4'b0010, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);

    do_req("bad_bank", 1'b0, 32'h2000, SIZE_WORD, 32'h0, 32'h0, 1'b1, 1);
    chk_beats("bad_bank", 0, 1'b0, 2'b00, 10'd0, 4'h0, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);
    do_req("bad_size", 1'b0, 32'h0000, 2'd3, 32'h0, 32'h0, 1'b1, 1);
    chk_beats("bad_size", 0, 1'b0, 2'b00, 10'd0, 4'h0, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);
    do_req("bad_split_bank", 1'b0, 32'h1FFE, SIZE_WORD, 32'h0, 32'h0, 1'b1, 1);
    chk_beats("bad_split_bank", 0, 1'b0, 2'b00, 10'd0, 4'h0, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);

`ifdef SRAM_CTRL_SPLIT_MISALIGNED_EN
    do_req("split_xbank", 1'b0, 32'h0FFE, SIZE_WORD, 32'h0, 32'h3344AABB, 1'b0, 5);
    chk_beats("split_xbank", 2, 1'b0, 2'b01, 10'h3FF, 4'b1100, 32'h0, 2'b10, 10'd0, 4'b0011, 32'h0);
    do_req("split_word1", 1'b0, 32'h0001, SIZE_WORD, 32'h0, 32'h00AABBCC, 1'b0, 5);
    chk_beats("split_word1", 2, 1'b0, 2'b01, 10'd0, 4'b1110, 32'h0, 2'b01, 10'd1, 4'b0001, 32'h0);
    do_req("split_wr_half", 1'b1, 32'h0003, SIZE_HALF, 32'h0000BEEF, 32'h0, 1'b0, 5);
    chk_beats("split_wr_half", 2, 1'b1, 2'b01, 10'd0, 4'b1000, 32'hEF000000, 2'b01, 10'd1, 4'b0001, 32'h000000BE);
    do_req("split_rd_half", 1'b0, 32'h0003, SIZE_HALF, 32'h0, 32'h0000BEEF, 1'b0, 5);
    chk_beats("split_rd_half", 2, 1'b0, 2'b01, 10'd0, 4'b1000, 32'h0, 2'b01, 10'd1, 4'b0001, 32'h0);
`else
    do_req("nosplit_xbank", 1'b0, 32'h0FFE, SIZE_WORD, 32'h0, 32'h0, 1'b1, 1);
    chk_beats("nosplit_xbank", 0, 1'b0, 2'b00, 10'd0, 4'h0, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);
    do_req("nosplit_wr_half", 1'b1, 32'h0003, SIZE_HALF, 32'h0000BEEF, 32'h0, 1'b1, 1);
    chk_beats("nosplit_wr_half", 0, 1'b1, 2'b00, 10'd0, 4'h0, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);
    chk("idle_ce_inverted", 64'(sram_ce), 64'd3);
`endif

    beats.delete();
    @(negedge clk);
    bus.req = 1'b1; bus.wen = 1'b0; bus.addr = 32'h0; bus.size = SIZE_WORD; bus.wdata = 32'h0;
    @(posedge clk);
    #1 bus.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ce_active", 64'(sram_ce), 64'(2'b01 ^ CE_INV));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ce", 64'(sram_ce), 64'(CE_INV));
    chk("rst_mid_be", 64'(sram_byte_en), 64'(BE_INV));
    chk("rst_mid_we", 64'(sram_we), 64'd0);
    got = bus.ready;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = got | bus.ready;
    end
    chk("rst_mid_no_ready", 64'(got), 64'd0);

    do_req("post_rst", 1'b0, 32'h1004, SIZE_WORD, 32'h0, 32'h11223344, 1'b0, 3);
    chk_beats("post_rst", 1, 1'b0, 2'b10, 10'd1, 4'hF, 32'h0, 2'b00, 10'd0, 4'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Parametrised, sequential SRAM access controller between the on-chip bus slave and N external/macro SRAM banks. Accepts one byte/half/word request at a time, decodes the bank and the byte lanes, holds chip-enable and address for a programmable number of wait states, and returns right-justified read data with a ready pulse. Optionally splits misaligned accesses into two SRAM beats, including across a bank boundary.

## Interface
- N_SRAM, 2: number of banks; 1..8.
- SRAM_DEPTH, 1024: 32-bit words per bank; power of two.
- ADDR_W, 32: byte address width.
- WAIT_STATES, 1: extra cycles each SRAM beat is held; 0..15.
- INVERT_BYTE_EN, 4'hF: XOR mask applied to sram_byte_en (4'hF means active-low lanes).
- INVERT_CE_EN, '1: XOR mask applied to sram_ce.
- CLK  in  1  clock; everything is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req  in  1  request; sampled only in IDLE.
- wen  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  byte address.
- size  in  2  0 byte, 1 half, 2 word, 3 reserved.
- wdata  in  32  right-justified write data.
- ready  out  1  one-cycle completion pulse.
- error  out  1  valid with ready; request rejected.
- rdata  out  32  right-justified, zero-extended read data; valid with ready, held until next ready.
- sram_ce  out  N_SRAM  one-hot bank enable, XOR INVERT_CE_EN.
- sram_we  out  1  active-high write strobe.
- sram_addr  out  $clog2(SRAM_DEPTH)  word address within bank.
- sram_byte_en  out  4  lane enables, XOR INVERT_BYTE_EN.
- sram_wdata  out  32  lane-aligned write data.
- sram_rdata  in  32  lane-aligned read data, sampled on last cycle of a beat.

## Operation
- States: IDLE, ACCESS, ACCESS2, DONE.
- IDLE: on req, latch addr/size/wen/wdata. Bank = addr / (4*SRAM_DEPTH); word = addr[2 +: $clog2(SRAM_DEPTH)]; offset o = addr[1:0].
- Illegal if size==3, or bank >= N_SRAM, or (split needed and bank of second beat >= N_SRAM). Illegal: go to DONE with error=1; no CE ever asserted.
- Lane masks: byte 4'b0001<<o; half 4'b0011<<o; word 4'hF<<o (truncated to 4 bits). Split needed when half at o==3 or word at o!=0.
- ACCESS: drive sram_ce one-hot for bank, sram_addr, beat-0 mask, sram_we=wen, sram_wdata = wdata<<(8*o). Held for WAIT_STATES+1 cycles via down-counter. Last cycle: capture enabled read lanes. Then ACCESS2 if split, else DONE.
- ACCESS2: next word address (word+1; wraps to 0 of bank+1 at SRAM_DEPTH-1); mask = remaining lanes from bit 0 (half: 4'b0001; word: 4'hF>>(4-o)); sram_wdata = wdata>>(8*(4-o)). Same hold length.
- rdata byte k = byte (o+k) of {beat1,beat0}; bytes above size are zero.
- DONE: ready=1 one cycle, return to IDLE. req high in that cycle is ignored; sampled again next cycle.
- Outside ACCESS/ACCESS2: sram_ce and sram_byte_en inactive (after inversion), sram_we=0.

## Timing
- Reset values: ready=0, error=0, rdata=0, sram_ce=INVERT_CE_EN, sram_byte_en=INVERT_BYTE_EN, sram_we=0, sram_addr=0, sram_wdata=0; state IDLE, counter 0.
- Single beat: req sampled cycle T; ACCESS T+1..T+1+W; ready at T+2+W. Split: ready at T+3+2W. Illegal: ready+error at T+1.
- RST during any state: next cycle all outputs at reset values, transaction dropped, no ready.
- All outputs registered; no combinational path from req/addr to SRAM pins.

## Configuration
- SRAM_CTRL_SPLIT_MISALIGNED_EN defined: split behaviour above, ACCESS2 present.
- Undefined: any access needing a split is illegal (error at T+1, no SRAM cycle); ACCESS2 not built.

## Structure
- Package sram_ctrl_pkg: size encodings (SIZE_BYTE/HALF/WORD), state enum, lane-mask function.
- One sub-module: sram_lane_align (combinational mask, write shift, read assembly), instanced once.

## Test plan
Config N_SRAM=2, SRAM_DEPTH=1024, WAIT_STATES=1, inversions 0 unless noted.
- Word write addr 0x1004, wdata 0x11223344 -> sram_ce=2'b10, sram_addr=1, byte_en=4'hF, we=1 for 2 cycles, ready at T+3, error=0.
- Byte read addr 0x0002, sram_rdata 0xAABBCCDD -> byte_en=4'b0100, rdata=0x000000BB.
- Macro on, word read 0x0FFE, bank0 word 0x3FF=0xAABBCCDD, bank1 word 0=0x11223344 -> beat0 ce=01 be=1100, beat1 ce=10 addr 0 be=0011, rdata=0x3344AABB, ready at T+5.
- Word read 0x2000 -> ready+error at T+1, sram_ce never active; size=3 same.
- Macro off, half write 0x0003 -> error at T+1, no CE; INVERT_CE_EN='1 shows ce=2'b11 idle.
- RST in first ACCESS cycle -> next cycle ce/be inactive, no ready; new request then completes normally.
